// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
//
// Push-button sequencing controller for the 16-bit hex-display counter.
// Each of the four raw, active-low keys is synchronised, debounced and turned
// into a single-cycle press event. The events drive a two-state STOP/RUN
// machine, a prescaled auto-count, and the counter value shown on the hex
// displays (nibble 0 -> HEX0).
//
// Ports:
//   CLOCK_50    in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   KEY         in   4      raw active-low keys: [0] step, [1] clear,
//                           [2] run/stop toggle, [3] direction toggle
//   value       out  WIDTH  counter value
//   running     out  1      1 = RUN state
//   dir_down    out  1      1 = count down, 0 = count up
//   step_pulse  out  1      one-cycle pulse alongside each step/tick update
// -----------------------------------------------------------------------------
module counter_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_DIV        = 50000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [3:0]       KEY,
    output logic [WIDTH-1:0] value,
    output logic             running,
    output logic             dir_down,
    output logic             step_pulse
);

    // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-1: the
    // flip happens on the edge that would otherwise make it DEBOUNCE_CYCLES.
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;

    localparam int KEY_STEP  = 0;
    localparam int KEY_CLEAR = 1;
    localparam int KEY_RUN   = 2;
    localparam int KEY_DIR   = 3;

    logic [3:0] press_ev;

    // -------------------------------------------------------------------------
    // Per-key synchroniser, debouncer and press detector
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic            sync1_q;
            logic            sync2_q;
            logic            deb_q;
            logic            deb_d;
            logic            deb_dly_q;
            logic            press_q;
            logic            press_d;
            logic [DB_W-1:0] cnt_q;
            logic [DB_W-1:0] cnt_d;

            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                if (sync2_q != deb_q) begin
                    if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_d = ~deb_q;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end
                // Press is detected one cycle after the debounced state has
                // already fallen, which gives the registered event its
                // fixed latency from the first low sample.
                press_d = deb_dly_q & ~deb_q;
            end

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    sync1_q   <= 1'b1;
                    sync2_q   <= 1'b1;
                    deb_q     <= 1'b1;
                    deb_dly_q <= 1'b1;
                    press_q   <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= KEY[gi];
                    sync2_q   <= sync1_q;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_q;
                    press_q   <= press_d;
                    cnt_q     <= cnt_d;
                end
            end

            assign press_ev[gi] = press_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // STOP/RUN machine, prescaler and counter
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PS_W-1:0]  presc_q;
    logic [PS_W-1:0]  presc_d;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             dir_q;
    logic             dir_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             tick;

    assign tick = (state_q == ST_RUN) && (presc_q == PS_W'(AUTO_DIV - 1));

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        value_d = value_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;

        if (press_ev[KEY_RUN]) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end

        // Only a RUN->RUN cycle advances the prescaler; entering RUN,
        // leaving RUN and sitting in STOP all leave it at 0.
        if (state_q == ST_RUN && state_d == ST_RUN && !press_ev[KEY_CLEAR]) begin
            presc_d = tick ? '0 : presc_q + PS_W'(1);
        end

        if (press_ev[KEY_DIR]) begin
            dir_d = ~dir_q;
        end

        // Step and tick together collapse to one change; the direction used
        // is the one in force before any simultaneous toggle.
        if (press_ev[KEY_CLEAR]) begin
            value_d = '0;
        end else if (press_ev[KEY_STEP] || tick) begin
            value_d = dir_q ? (value_q - WIDTH'(1)) : (value_q + WIDTH'(1));
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_STOP;
            presc_q <= '0;
            value_q <= '0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            value_q <= value_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
        end
    end

    assign value      = value_q;
    assign running    = (state_q == ST_RUN);
    assign dir_down   = dir_q;
    assign step_pulse = pulse_q;

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencing controller for the board's 16-bit hex-display counter, replacing direct key clocking. It synchronises and debounces the four push-buttons in the CLOCK_50 domain and turns presses into single-cycle commands: step, clear, run/stop and direction. It runs a prescaled auto-count mode and drives the 16-bit value to the four hex7seg decoders.

Parameters:
WIDTH, 16, counter width in bits.
DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a key change (10 ms at 50 MHz; min 2).
AUTO_DIV, 50000000, CLOCK_50 cycles per auto-count tick in RUN (min 2).

Ports:
CLOCK_50  input  1  system clock.
reset  input  1  synchronous, active-high reset.
KEY  input  4  raw active-low push-buttons: [0] step, [1] clear, [2] run/stop toggle, [3] direction toggle.
value  output  WIDTH  counter value, to hex7seg HEX0..HEX3 (nibble 0 to HEX0).
running  output  1  1 = RUN state.
dir_down  output  1  1 = count down, 0 = count up.
step_pulse  output  1  one-cycle pulse in the cycle after each step/tick value change; not asserted on clear.

Behaviour:
- Reset (sampled on the CLOCK_50 rising edge): value=0, running=0, dir_down=0, step_pulse=0, prescaler=0, sync flops=1, debounced state=1 (released), debounce counters=0. Reset has priority over everything and aborts any debounce or prescale in progress.
- Per key:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised input differs from the debounced state and clears otherwise.
  - After DEBOUNCE_CYCLES consecutive differing samples, the debounced state flips and the counter clears.
  - A 1-to-0 flip (press) gives a registered one-cycle press event. Release gives no event. A held key gives exactly one event.
  - Glitches shorter than DEBOUNCE_CYCLES give no event.
- Latency: counting the first edge that samples KEY low as edge 1, the press event is high after edge DEBOUNCE_CYCLES+3. The resulting register update (value, running or dir_down) occurs at edge DEBOUNCE_CYCLES+4.
- State machine: STOP (running=0) and RUN (running=1). A run/stop event toggles the state. Entering RUN starts the prescaler from 0. In STOP the prescaler is held at 0.
- Prescaler in RUN counts 0..AUTO_DIV-1. Tick = prescaler at AUTO_DIV-1 (it wraps to 0 on that edge). The first tick after entering RUN comes AUTO_DIV cycles later.
- Step event or tick: value <= value+1 if dir_down=0, else value-1, modulo 2^WIDTH (0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF). Step works in both STOP and RUN.
- Clear event: value <= 0 and prescaler <= 0. running and dir_down are unchanged.
- Simultaneous events in one cycle:
  - Clear beats step/tick for value.
  - Step and tick together give a single change of 1.
  - Direction toggle with step/tick: the step uses the pre-toggle direction; the new direction applies from the next cycle.
  - Run/stop and direction toggles still apply alongside a clear.
- step_pulse is high for exactly one cycle after each step/tick update, and 0 otherwise.
- A key still held low when reset deasserts is debounced from the released state and produces one press event DEBOUNCE_CYCLES+3 edges after reset deasserts.

Test Plan:
(All with DEBOUNCE_CYCLES=4, AUTO_DIV=8.)
1. Reset, hold KEY[0] low for 20 cycles -> value goes 0 to 1 exactly at edge 8. A single step_pulse is seen. No further change while held or on release.
2. KEY[0] low for 3 cycles then high, repeated 5 times -> value stays 0 and step_pulse never asserts.
3. Press KEY[2] -> running=1. value increments every 8 cycles: 1, 2, 3. Press KEY[2] again -> running=0 and value freezes.
4. From value=0, press KEY[3] then KEY[0] -> dir_down=1 and value=0xFFFF (wrap). Force 0xFFFF upward with dir_down=0 plus one step -> 0x0000.
5. In RUN, press KEY[1] so the clear lands on the same cycle as a tick -> value=0, no step_pulse, running stays 1, and the next tick comes 8 cycles later with value=1.
6. Assert reset mid-debounce and mid-prescale with value=0x1234 -> all outputs return to reset values on the next edge, and no stale event fires afterwards.
